// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus edge-triggered memory port of the data-memory initiator.
// slave: the controller's view; master: the pipeline/memory side that drives it.
interface mem_access_ctrl_if #(
  parameter int unsigned WORD_SIZE = 32
) ();
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [1:0]           req_size_i;
  logic                 req_unsigned_i;
  logic [WORD_SIZE-1:0] req_base_i;
  logic [WORD_SIZE-1:0] req_offset_i;
  logic [WORD_SIZE-1:0] req_wdata_i;
  logic                 resp_valid_o;
  logic                 resp_ready_i;
  logic [WORD_SIZE-1:0] resp_rdata_o;
  logic                 resp_err_o;
  logic                 en_mem_o;
  logic                 mem_read_o;
  logic                 mem_write_o;
  logic [WORD_SIZE-1:0] addr_base_o;
  logic [WORD_SIZE-1:0] addr_offset_o;
  logic [WORD_SIZE-1:0] val_o;
  logic [WORD_SIZE-1:0] val_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_base_i, req_offset_i,
           req_wdata_i, resp_ready_i, val_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, en_mem_o, mem_read_o,
           mem_write_o, addr_base_o, addr_offset_o, val_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_base_i, req_offset_i,
           req_wdata_i, resp_ready_i, val_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, en_mem_o, mem_read_o,
           mem_write_o, addr_base_o, addr_offset_o, val_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: byte/half/word loads and stores, sub-word stores done as
// read-modify-write, one response per request with an error flag for rejected accesses.
module mem_access_ctrl #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned MEM_SIZE  = 1024
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StRdSetup, StRdEn, StRdWait, StWrSetup, StWrEn, StResp
  } state_e;

  state_e state_q, state_d;

  logic                 we_q, uns_q, err_q;
  logic [1:0]           size_q;
  logic [WORD_SIZE-1:0] addr_q, wdata_q, buf_q;

  logic [WORD_SIZE-1:0] byte_addr, word_idx, load_data, merge_data;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;
  logic                 req_err, accept;

  assign byte_addr = bus.req_base_i + bus.req_offset_i;
  assign word_idx  = byte_addr >> 2;
  assign accept    = (state_q == StIdle) && bus.req_valid_i;

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size_i)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = byte_addr[0];
      2'b10:   req_err = |byte_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (word_idx >= WORD_SIZE'(MEM_SIZE)) req_err = 1'b1;
  end

  // State register plus latched request and read buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we_i;
        uns_q   <= bus.req_unsigned_i;
        err_q   <= req_err;
        size_q  <= bus.req_size_i;
        addr_q  <= byte_addr;
        wdata_q <= bus.req_wdata_i;
      end
      if (state_q == StRdWait) buf_q <= bus.val_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid_i) begin
          if (req_err)                                       state_d = StResp;
          else if (!bus.req_we_i || bus.req_size_i != 2'b10) state_d = StRdSetup;
          else                                               state_d = StWrSetup;
        end
      end
      StRdSetup: state_d = StRdEn;
      StRdEn:    state_d = StRdWait;
      StRdWait:  state_d = we_q ? StWrSetup : StResp;
      StWrSetup: state_d = StWrEn;
      StWrEn:    state_d = StResp;
      StResp:    if (bus.resp_ready_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Lane extraction and merge work from the latched address, so they hold steady
  // for the whole transaction and need no extra staging registers.
  always_comb begin
    byte_v = buf_q[{addr_q[1:0], 3'b000} +: 8];
    half_v = buf_q[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & byte_v[7]}}, byte_v};
      2'b01:   load_data = {{16{~uns_q & half_v[15]}}, half_v};
      default: load_data = buf_q;
    endcase
    merge_data = buf_q;
    case (size_q)
      2'b00:   merge_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merge_data[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merge_data = wdata_q;
    endcase
  end

  always_comb begin
    bus.req_ready_o   = (state_q == StIdle);
    bus.resp_valid_o  = (state_q == StResp);
    bus.resp_err_o    = (state_q == StResp) && err_q;
    bus.resp_rdata_o  = ((state_q == StResp) && !we_q && !err_q) ? load_data : '0;
    bus.en_mem_o      = (state_q == StRdEn) || (state_q == StWrEn);
    bus.mem_read_o    = (state_q == StRdSetup) || (state_q == StRdEn) || (state_q == StRdWait);
    // Write command stays up through the cycle after the strobe.
    bus.mem_write_o   = (state_q == StWrSetup) || (state_q == StWrEn) ||
                        ((state_q == StResp) && we_q && !err_q);
    bus.addr_base_o   = {2'b00, addr_q[WORD_SIZE-1:2]};
    bus.addr_offset_o = '0;
    bus.val_o         = merge_data;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of directed vectors, hand-written backpressure and
// reset-abort sequences, then random requests checked against a byte-level memory model.
module tb_mem_access_ctrl;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          pulses;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.WORD_SIZE(32)) bus ();

  mem_access_ctrl #(.WORD_SIZE(32), .MEM_SIZE(1024)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int rw_bad   = 0;

  // Edge-triggered memory acting on the strobe's rising edge.
  always @(posedge bus.en_mem_o) begin
    en_cnt++;
    if (!$isunknown(bus.addr_base_o) && (bus.addr_base_o + bus.addr_offset_o) < 1024) begin
      if (bus.mem_read_o)       bus.val_i = mem[bus.addr_base_o + bus.addr_offset_o];
      else if (bus.mem_write_o) mem[bus.addr_base_o + bus.addr_offset_o] = bus.val_o;
    end
  end

  always @(negedge clk) if (!rst && bus.mem_read_o === 1'b1 && bus.mem_write_o === 1'b1) rw_bad++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model(input vec_t v, output logic err, output logic [31:0] rdata,
                       output int lat, output int pulses);
    logic [31:0] a;
    int unsigned w, ln, nb;
    longint unsigned word, val, lim, mask;
    a  = v.base + v.off;
    w  = a / 4;
    ln = a % 4;
    case (v.size)
      2'd0:    nb = 1;
      2'd1:    nb = 2;
      2'd2:    nb = 4;
      default: nb = 0;
    endcase
    err = (nb == 0) || (w >= 1024);
    if (!err && (a % nb) != 0) err = 1'b1;
    rdata = '0;
    if (err) begin
      lat = 1; pulses = 0;
      return;
    end
    lim  = 64'd1 << (8 * nb);
    word = ref_mem[w];
    if (!v.we) begin
      val = (word >> (8 * ln)) % lim;
      if (!v.uns && val >= lim / 2) val = val + (64'd1 << 32) - lim;
      rdata = val[31:0];
      lat = 4; pulses = 1;
    end else begin
      mask = (lim - 1) << (8 * ln);
      word = (word & ~mask) | ((longint'(v.wdata) % lim) << (8 * ln));
      ref_mem[w] = word[31:0];
      lat    = (nb == 4) ? 3 : 6;
      pulses = (nb == 4) ? 1 : 2;
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req_we_i       = v.we;
    bus.req_size_i     = v.size;
    bus.req_unsigned_i = v.uns;
    bus.req_base_i     = v.base;
    bus.req_offset_i   = v.off;
    bus.req_wdata_i    = v.wdata;
    bus.req_valid_i    = 1'b1;
  endtask

  task automatic run_req(input vec_t v, output logic [31:0] rdata, output logic err,
                         output int lat, output int pulses);
    int start;
    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready_o), 32'd1);
    drive(v);
    start = en_cnt;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    lat = 1;
    while (!bus.resp_valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = bus.resp_rdata_o;
    err   = bus.resp_err_o;
    @(posedge clk); #1;
    pulses = en_cnt - start;
  endtask

  task automatic check_resp(input string tag, input vec_t e, input logic [31:0] rdata,
                            input logic err, input int lat, input int pulses);
    chk({tag, ".err"},    32'(err),    32'(e.err));
    chk({tag, ".rdata"},  rdata,       e.rdata);
    chk({tag, ".lat"},    32'(lat),    32'(e.lat));
    chk({tag, ".pulses"}, 32'(pulses), 32'(e.pulses));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".req_ready"},  32'(bus.req_ready_o),  32'd1);
    chk({tag, ".resp_valid"}, 32'(bus.resp_valid_o), 32'd0);
    chk({tag, ".resp_err"},   32'(bus.resp_err_o),   32'd0);
    chk({tag, ".resp_rdata"}, bus.resp_rdata_o,      32'd0);
    chk({tag, ".en_mem"},     32'(bus.en_mem_o),     32'd0);
    chk({tag, ".rd_wr"},      32'({bus.mem_read_o, bus.mem_write_o}), 32'd0);
    chk({tag, ".addr"},       bus.addr_base_o | bus.addr_offset_o, 32'd0);
    chk({tag, ".val_o"},      bus.val_o,             32'd0);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v, m;
    logic [31:0] rdata;
    logic err;
    int lat, pulses, start, bad;

    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    bus.req_valid_i = 1'b0;
    bus.req_we_i = 1'b0;
    bus.req_size_i = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_base_i = '0;
    bus.req_offset_i = '0;
    bus.req_wdata_i = '0;
    bus.resp_ready_i = 1'b1;
    bus.val_i = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    en_cnt = 0;

    //            we    size   uns   base          off       wdata         err   rdata     lat p
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h10,       32'h0,  32'hDEADBEEF, 1'b0, 32'h0,        3, 1});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h0C,       32'h4,  32'h0,        1'b0, 32'hDEADBEEF, 4, 1});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h20,       32'h0,  32'h80FF7F01, 1'b0, 32'h0,        3, 1});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h23,       32'h0,  32'h0,        1'b0, 32'hFFFFFF80, 4, 1});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h23,       32'h0,  32'h0,        1'b0, 32'h00000080, 4, 1});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h20,       32'h0,  32'h0,        1'b0, 32'h00007F01, 4, 1});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h20,       32'h0,  32'h11223344, 1'b0, 32'h0,        3, 1});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h21,       32'h0,  32'h123456AA, 1'b0, 32'h0,        6, 2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h20,       32'h0,  32'h0,        1'b0, 32'h1122AA44, 4, 1});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h22,       32'h0,  32'h1234BEEF, 1'b0, 32'h0,        6, 2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h20,       32'h0,  32'h0,        1'b0, 32'hBEEFAA44, 4, 1});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h22,       32'h0,  32'h0,        1'b0, 32'h0000BEEF, 4, 1});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h22,       32'h0,  32'h0,        1'b0, 32'hFFFFBEEF, 4, 1});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h21,       32'h0,  32'h0,        1'b1, 32'h0,        1, 0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h22,       32'h0,  32'h0,        1'b1, 32'h0,        1, 0});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h20,       32'h0,  32'h0,        1'b1, 32'h0,        1, 0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h1000,     32'h0,  32'h0,        1'b1, 32'h0,        1, 0});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'hFFC,      32'h4,  32'hCAFEF00D, 1'b1, 32'h0,        1, 0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'hFFFFFFF0, 32'h30, 32'h0,        1'b0, 32'hBEEFAA44, 4, 1});

    foreach (tbl[i]) begin
      model(tbl[i], m.err, m.rdata, m.lat, m.pulses);
      run_req(tbl[i], rdata, err, lat, pulses);
      check_resp($sformatf("vec%0d", i), tbl[i], rdata, err, lat, pulses);
    end

    // Backpressure: response held 5 cycles while a second request waits.
    bus.resp_ready_i = 1'b0;
    @(negedge clk);
    drive('{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0});
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 10 && !bus.resp_valid_o; i++) begin
      @(posedge clk); #1;
    end
    start = en_cnt;
    drive('{1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0});
    for (int i = 0; i < 5; i++) begin
      chk("bp.resp_valid", 32'(bus.resp_valid_o), 32'd1);
      chk("bp.rdata",      bus.resp_rdata_o,      32'hBEEFAA44);
      chk("bp.err",        32'(bus.resp_err_o),   32'd0);
      chk("bp.req_ready",  32'(bus.req_ready_o),  32'd0);
      @(posedge clk); #1;
    end
    chk("bp.no_mem_activity", 32'(en_cnt - start), 32'd0);
    bus.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp.idle_ready", 32'(bus.req_ready_o), 32'd1);
    chk("bp.idle_valid", 32'(bus.resp_valid_o), 32'd0);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    chk("bp.accepted", 32'(bus.req_ready_o), 32'd0);
    lat = 1;
    while (!bus.resp_valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.next_lat",   32'(lat),         32'd4);
    chk("bp.next_rdata", bus.resp_rdata_o, 32'h0000BEEF);
    @(posedge clk); #1;

    // Reset while the read strobe of a sub-word store is high.
    @(negedge clk);
    drive('{1'b1, 2'd0, 1'b0, 32'h21, 32'h0, 32'h55, 1'b0, 32'h0, 0, 0});
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("rst.in_rd_en", 32'(bus.en_mem_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    start = en_cnt;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst.no_resp", 32'(bus.resp_valid_o), 32'd0);
    end
    chk("rst.no_strobe", 32'(en_cnt - start), 32'd0);
    chk("rst.mem_kept",  mem[8],              32'hBEEFAA44);
    v = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 32'hBEEFAA44, 4, 1};
    run_req(v, rdata, err, lat, pulses);
    check_resp("rst.after", v, rdata, err, lat, pulses);

    // Random requests against the model.
    for (int n = 0; n < 200; n++) begin
      int unsigned widx, r;
      logic [31:0] a;
      r = $urandom_range(7);
      v.we   = 1'($urandom_range(1));
      v.size = (r < 7) ? 2'(r % 3) : 2'd3;
      v.uns  = 1'($urandom_range(1));
      widx   = ($urandom_range(15) == 0) ? 1024 + $urandom_range(7) : $urandom_range(63);
      a      = widx * 4 + $urandom_range(3);
      v.base = $urandom;
      v.off  = a - v.base;
      v.wdata = $urandom;
      model(v, m.err, m.rdata, m.lat, m.pulses);
      run_req(v, rdata, err, lat, pulses);
      check_resp($sformatf("rand%0d", n), m, rdata, err, lat, pulses);
    end

    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", 32'(bad), 32'd0);
    chk("rw_exclusive", 32'(rw_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator side of the data-memory interface: accepts load/store requests from the pipeline MEM stage over a valid/ready handshake and drives the edge-triggered `memory` port (`en_mem`, `mem_read`, `mem_write`, base/offset, write value). It converts byte addresses to word indices, performs byte/half/word accesses with sign or zero extension, and implements sub-word stores as read-modify-write. It returns a single response per request, with an error flag for misaligned, illegal-size or out-of-range accesses.

## Interface
- `WORD_SIZE`, 32: data width. Only 32 is supported; byte-lane logic is fixed to 4 lanes.
- `MEM_SIZE`, 1024: memory depth in words; used for the range check.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when high with `req_valid_i`.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned_i` in 1: load zero-extends when 1, sign-extends when 0.
- `req_base_i`, `req_offset_i` in WORD_SIZE: byte address = base + offset, mod 2^32.
- `req_wdata_i` in WORD_SIZE: store data; low byte/half used for sub-word stores.
- `resp_valid_o` out 1; `resp_ready_i` in 1: response handshake.
- `resp_rdata_o` out WORD_SIZE: extended load data; 0 for stores and errors.
- `resp_err_o` out 1: request rejected; memory was not touched.
- `en_mem_o` out 1: memory strobe. Memory acts on its rising edge.
- `mem_read_o`, `mem_write_o` out 1: memory command.
- `addr_base_o`, `addr_offset_o` out WORD_SIZE: word index = byte_addr >> 2; offset is always 0.
- `val_o` out WORD_SIZE: write word to memory.
- `val_i` in WORD_SIZE: read word from memory.

## Operation
- States: IDLE, RD_SETUP, RD_EN, RD_WAIT, WR_SETUP, WR_EN, RESP.
- IDLE: `req_ready_o`=1. On accept, latch all request fields and byte_addr, then check for errors:
  - size 11;
  - half with addr[0]≠0;
  - word with addr[1:0]≠0;
  - word index ≥ MEM_SIZE.
  - On error, go to RESP with err=1. Otherwise a load or sub-word store goes to RD_SETUP, and a word store goes to WR_SETUP.
- RD_SETUP: drive address and `mem_read_o`=1 with `en_mem_o`=0. RD_EN: `en_mem_o`=1. RD_WAIT: `en_mem_o`=0 and register `val_i` into the read buffer.
  - After RD_WAIT, a load goes to RESP and a sub-word store goes to WR_SETUP.
- Load extraction: lane = addr[1:0]. Byte = buf[8*lane+:8]; half = buf[16*addr[1]+:16]. Extend per `req_unsigned_i`. A word load returns buf unchanged.
- WR_SETUP: `mem_read_o`=0, `mem_write_o`=1, `en_mem_o`=0. Set `val_o` to:
  - word store: wdata;
  - sub-word store: buf with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]; other lanes preserved.
- WR_EN: `en_mem_o`=1, then go to RESP.
- RESP: `resp_valid_o`=1, data and err held stable until `resp_ready_i`=1, then IDLE. `req_ready_o`=0 in every non-IDLE state.
- `mem_read_o` and `mem_write_o` are never both 1.
- Address, command and `val_o` are stable from the SETUP state through the cycle after EN.
- Reset: next state IDLE. Reset values of all outputs are 0, except `req_ready_o`=1 in the IDLE state that follows reset. Read buffer and latched request are cleared to 0.
- Reset mid-operation aborts the transaction and no response is issued. If reset arrives after WR_EN, the write has already occurred and stands. `en_mem_o` is 0 from the cycle after reset asserts.

## Timing
- All outputs are registered or decoded from state; there is no combinational path from `req_*` to memory-side outputs.
- `en_mem_o` is high for exactly 1 cycle per access, always preceded by at least 1 setup cycle with stable address and command.
- Latency from the accept edge to `resp_valid_o`=1:
  - load: 4 cycles;
  - word store: 3 cycles;
  - sub-word store: 6 cycles;
  - error: 1 cycle.
- `resp_ready_i` held high gives back-to-back operation: the next request is accepted in the cycle after RESP completes.

## Test plan
- Word store then load: store 0xDEADBEEF at byte 0x10, then load word from base 0x0C, offset 4.
  - Store: `addr_base_o`=4, one `en_mem_o` pulse with write=1, response 3 cycles after accept.
  - Load: returns 0xDEADBEEF 4 cycles after accept.
- Byte loads on word 0x80FF7F01 at byte 0x20:
  - signed byte at 0x23 → 0xFFFFFF80;
  - unsigned byte at 0x23 → 0x00000080;
  - signed half at 0x20 → 0x00007F01.
- Sub-word store RMW: with mem[8]=0x11223344, store byte 0xAA at 0x21 and then half 0xBEEF at 0x22.
  - mem[8] becomes 0x1122AA44, then 0xBEEFAA44.
  - Each store shows 2 `en_mem_o` pulses (read then write) and a 6-cycle latency.
- Errors: half at 0x21, word at 0x22, size 11, and word index 1024.
  - Each gives `resp_err_o`=1 and `resp_rdata_o`=0 after 1 cycle, with no `en_mem_o` pulse.
- Backpressure: hold `resp_ready_i`=0 for 5 cycles in RESP.
  - `resp_*` stable, `req_ready_o`=0 and no memory activity throughout.
  - A new request is accepted the cycle after the handshake.
- Reset in RD_EN of a sub-word store: assert `rst_i` for 1 cycle.
  - No write occurs, memory is unchanged, all outputs return to reset values, and the next request completes normally.
